add_round_key_ctrl: RTL
=======================

ADD_ROUND_KEY_CTRL -- requirements
Module: add_round_key_ctrl

Interface
REQ-001 Parameter DATA_W, default 128: state/key width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter NUM_ROUNDS, default 10: final round index (10/12/14 for AES-128/192/256); SHALL be 1..15.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: data_in/key/in_first are valid.
REQ-006 Port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 Port in_first, input, 1: beat is round 0 (initial AddRoundKey) of a new block.
REQ-008 Port data_in, input, DATA_W: state entering AddRoundKey.
REQ-009 Port key, input, DATA_W: round key.
REQ-010 Port data_out, output, DATA_W: registered XOR result.
REQ-011 Port out_valid, output, 1: data_out holds an unconsumed result.
REQ-012 Port out_ready, input, 1: downstream consumes data_out.
REQ-013 Port round_idx, output, 4: round index of the result in data_out.
REQ-014 Port done, output, 1: out_valid and round_idx == NUM_ROUNDS.
REQ-015 Port ciphertext, output, DATA_W: data_out when done, else all-zero.
REQ-016 Port seq_err, output, 1: sticky round-sequencing error flag.

Function
REQ-017 Accept = in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational, one-entry register, no bubble).
REQ-018 On accept, data_out SHALL load data_in ^ key on the next edge, and out_valid SHALL be 1 on that edge; latency 1 cycle.
REQ-019 out_valid SHALL clear on an edge with out_valid && out_ready and no accept; with both, it SHALL stay 1 and data_out SHALL take the new beat.
REQ-020 data_out, round_idx and out_valid SHALL hold while out_valid && !out_ready.
REQ-021 FSM states: IDLE (no block open), RUN (round_idx < NUM_ROUNDS), FIN (round_idx == NUM_ROUNDS).
REQ-022 Accept with in_first in any state: round_idx <= 0, next state RUN; an open block is abandoned without error.
REQ-023 Accept without in_first in RUN: round_idx <= round_idx + 1; next state FIN when the new value equals NUM_ROUNDS, else RUN.
REQ-024 Accept without in_first in IDLE or FIN: seq_err <= 1; the beat is still XORed and output, round_idx unchanged, state unchanged.
REQ-025 FIN SHALL move to IDLE on the edge where the final result is consumed (out_valid && out_ready) with no accepted beat.
REQ-026 done and ciphertext SHALL be combinational from registered state; no other output is combinational from inputs except in_ready.
REQ-027 seq_err SHALL clear only on reset.

Reset
REQ-028 While reset is high: data_out = 0, out_valid = 0, round_idx = 0, seq_err = 0, state = IDLE; hence done = 0, ciphertext = 0, in_ready = 1.
REQ-029 Reset asserted mid-block SHALL discard the block immediately (asynchronous), with no partial result emitted after release.

Configuration
REQ-030 Macro ADD_ROUND_PARITY_EN: when defined, output port parity [DATA_W/8-1:0] SHALL exist, registered alongside data_out, bit i = XOR of data_out byte i (even parity), reset 0.
REQ-031 Without ADD_ROUND_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Round 0, first=1, data_in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> next cycle data_out=00102030405060708090a0b0c0d0e0f0, round_idx=0, done=0, ciphertext=0.
REQ-033 Full block, NUM_ROUNDS=10, 11 beats back-to-back with out_ready=1 -> round_idx 0..10, done high only with round_idx=10, ciphertext=data_out there, state returns to IDLE.
REQ-034 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, data_out stable; then out_ready=1 with in_valid=1 -> new beat is accepted the same cycle.
REQ-035 Non-first beat after reset, or after FIN -> seq_err=1 and stays 1 until reset; in_first mid-block -> round_idx=0, seq_err unchanged.
REQ-036 Reset pulsed at round 5 -> out_valid=0, round_idx=0 immediately; a non-first beat after that sets seq_err.
REQ-037 With ADD_ROUND_PARITY_EN, data_out byte 0x01 -> parity bit 1, and byte 0x03 -> parity bit 0.

Source files
------------

// File: rtl/add_round_key_ctrl.sv
// add_round_key_ctrl
// Registered AES AddRoundKey stage with round sequencing.
// Each accepted beat XORs data_in with key into a one-entry output
// register. A small FSM tracks which round of the current block the
// registered result belongs to. It raises done and ciphertext on the
// final round, and sets a sticky seq_err when a non-first beat arrives
// while no block is open.
//
// Optional feature: define ADD_ROUND_PARITY_EN to add the parity output.
// It carries one even-parity bit per byte of data_out and is registered
// alongside data_out.
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   in_valid    : data_in / key / in_first are valid
//   in_ready    : a beat is accepted this cycle (combinational)
//   in_first    : beat is round 0 of a new block
//   data_in     : state entering AddRoundKey
//   key         : round key
//   data_out    : registered data_in ^ key
//   out_valid   : data_out holds an unconsumed result
//   out_ready   : downstream consumes data_out
//   round_idx   : round index of the result in data_out
//   done        : out_valid and round_idx == NUM_ROUNDS
//   ciphertext  : data_out when done, else zero
//   seq_err     : sticky sequencing error, cleared only by reset
//   parity      : (ADD_ROUND_PARITY_EN only) per-byte XOR of data_out

module add_round_key_ctrl #(
   parameter int DATA_W     = 128,
   parameter int NUM_ROUNDS = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_first,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] key,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        round_idx,
   output logic              done,
   output logic [DATA_W-1:0] ciphertext,
   output logic              seq_err
`ifdef ADD_ROUND_PARITY_EN
   ,
   output logic [DATA_W/8-1:0] parity
`endif
);

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic [3:0]        round_q, round_d;
   logic              err_q, err_d;
   logic              accept;

   // A one-entry output register. It can take a new beat whenever it is
   // empty or is being drained in this same cycle, so streaming needs no
   // bubble.
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Next-state logic for the datapath register and the round sequencer.
   // Everything holds by default. Only an accept or a drain moves anything.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      round_d = round_q;
      err_d   = err_q;
      if (accept) begin
         data_d  = data_in ^ key;
         valid_d = 1'b1;
         if (in_first) begin
            // A new block always restarts at round 0 and silently drops any open one.
            round_d = 4'd0;
            state_d = RUN;
         end else begin
            unique case (state_q)
               RUN: begin
                  round_d = round_q + 4'd1;
                  state_d = ((round_q + 4'd1) == LAST_ROUND) ? FIN : RUN;
               end
               default: begin
                  // No open block: the beat still passes through, only the flag records it.
                  err_d = 1'b1;
               end
            endcase
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
         if (state_q == FIN) begin
            state_d = IDLE;
         end
      end
   end

   // State register. Reset discards any block in flight at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         round_q <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         round_q <= round_d;
         err_q   <= err_d;
      end
   end

   assign data_out   = data_q;
   assign out_valid  = valid_q;
   assign round_idx  = round_q;
   assign seq_err    = err_q;
   assign done       = valid_q && (round_q == LAST_ROUND);
   assign ciphertext = done ? data_q : '0;

`ifdef ADD_ROUND_PARITY_EN
   logic [DATA_W/8-1:0] parity_q, parity_d;

   // Parity is computed from the next data value so it stays cycle-aligned with data_out.
   always_comb begin
      parity_d = '0;
      for (int i = 0; i < DATA_W/8; i++) begin
         parity_d[i] = ^data_d[i*8 +: 8];
      end
   end

   // Parity register, reset and updated together with data_out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_q <= '0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity = parity_q;
`endif

endmodule
